// File: rtl/ps2_frame_receiver_if.sv
// Receive-side stream bundle of the PS/2 frame receiver.
// master = receiver, slave = downstream consumer.
interface ps2_frame_receiver_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [CW-1:0]        rx_count;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_timeout;
  logic                 rx_overflow;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output rx_count,
    output rx_parity_err,
    output rx_frame_err,
    output rx_timeout,
    output rx_overflow
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  rx_count,
    input  rx_parity_err,
    input  rx_frame_err,
    input  rx_timeout,
    input  rx_overflow
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start/parity/stop checking,
// inactivity timeout and a show-ahead output FIFO.
module ps2_frame_receiver #(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_EN      = 1,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ps2_clk_edge,
  input  logic ps2_data,
  ps2_frame_receiver_if.master rx
);

  localparam int BW = $clog2(DATA_BITS);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic [TW-1:0]        tcnt;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic parity_err_q;
  logic frame_err_q;
  logic timeout_q;
  logic overflow_q;

  logic last_bit;
  logic expire;
  logic stop_edge;
  logic par_ok;
  logic good;
  logic empty;
  logic full;
  logic pop;
  logic push;

  assign last_bit  = bcnt == BW'(DATA_BITS - 1);
  assign expire    = (state != IDLE) && !ps2_clk_edge &&
                     (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign stop_edge = ps2_clk_edge && (state == STOP);
  assign par_ok    = (PARITY_EN == 0) || ((^shreg) ^ par);
  assign good      = stop_edge && par_ok && ps2_data;

  assign empty = count == '0;
  assign full  = count == CW'(FIFO_DEPTH);
  assign pop   = !empty && rx.rx_ready;
  assign push  = good && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (expire) begin
      state_nx = IDLE;
    end else if (ps2_clk_edge) begin
      unique case (state)
        IDLE:   if (enable && !ps2_data) state_nx = DATA;
        DATA:   if (last_bit)
                  state_nx = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY: state_nx = STOP;
        STOP:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt  <= '0;
      shreg <= '0;
      par   <= 1'b0;
      tcnt  <= '0;
    end else begin
      if (state == IDLE || ps2_clk_edge || expire) tcnt <= '0;
      else                                         tcnt <= tcnt + TW'(1);
      if (expire) begin
        bcnt  <= '0;
        shreg <= '0;
      end else if (ps2_clk_edge && state == DATA) begin
        shreg <= {ps2_data, shreg[DATA_BITS-1:1]};
        bcnt  <= last_bit ? '0 : bcnt + BW'(1);
      end
      if (ps2_clk_edge && state == PARITY) par <= ps2_data;
    end
  end

  // Storage needs no reset: rx_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      parity_err_q <= stop_edge && !par_ok;
      frame_err_q  <= stop_edge && par_ok && !ps2_data;
      timeout_q    <= expire;
      overflow_q   <= good && full && !pop;
    end
  end

  assign rx.rx_data       = empty ? '0 : mem[rd_ptr];
  assign rx.rx_valid      = !empty;
  assign rx.rx_count      = count;
  assign rx.rx_parity_err = parity_err_q;
  assign rx.rx_frame_err  = frame_err_q;
  assign rx.rx_timeout    = timeout_q;
  assign rx.rx_overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: 8-bit parity instance with short
// timeout plus a 7-bit no-parity instance, scoreboard on FIFO pops.
module tb_ps2_frame_receiver;

  localparam int GAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b1;
  logic pdata = 1'b1;
  logic edge0 = 1'b0;
  logic edge1 = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_to    = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  ps2_frame_receiver_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
  ps2_frame_receiver_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if1 ();

  ps2_frame_receiver #(
    .DATA_BITS(8), .PARITY_EN(1),
    .TIMEOUT_CYCLES(200), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst(rst), .enable(enable),
    .ps2_clk_edge(edge0), .ps2_data(pdata), .rx(if0)
  );

  ps2_frame_receiver #(
    .DATA_BITS(7), .PARITY_EN(0),
    .TIMEOUT_CYCLES(24000), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst(rst), .enable(enable),
    .ps2_clk_edge(edge1), .ps2_data(pdata), .rx(if1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (if0.rx_valid && if0.rx_ready) begin
        if (q0.size() == 0) chk("sb0_empty", q0.size(), 1);
        else chk("sb0_data", if0.rx_data, q0.pop_front());
      end
      if (if1.rx_valid && if1.rx_ready) begin
        if (q1.size() == 0) chk("sb1_empty", q1.size(), 1);
        else chk("sb1_data", if1.rx_data, q1.pop_front());
      end
      if (if0.rx_timeout) n_to++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int inst, input logic b,
                          input int gap);
    repeat (gap) tick();
    pdata = b;
    if (inst == 0) edge0 = 1'b1;
    else           edge1 = 1'b1;
    tick();
    edge0 = 1'b0;
    edge1 = 1'b0;
    pdata = 1'b1;
  endtask

  function automatic int gsel(input int idx, input int long_idx);
    return (idx == long_idx) ? 199 : GAP;
  endfunction

  task automatic send0(input logic [7:0] d, input logic p,
                       input logic s, input int long_idx,
                       input logic rdy_stop);
    send_bit(0, 1'b0, gsel(0, long_idx));
    for (int i = 0; i < 8; i++)
      send_bit(0, d[i], gsel(i + 1, long_idx));
    send_bit(0, p, gsel(9, long_idx));
    repeat (GAP) tick();
    if (rdy_stop) if0.rx_ready = 1'b1;
    send_bit(0, s, 0);
  endtask

  function automatic logic oddp(input logic [7:0] d);
    return ~^d;
  endfunction

  initial begin
    int n;
    int to0;
    logic [7:0] d;
    if0.rx_ready = 1'b1;
    if1.rx_ready = 1'b1;

    repeat (3) tick();
    chk("rst_valid", if0.rx_valid, 0);
    chk("rst_count", if0.rx_count, 0);
    chk("rst_data", if0.rx_data, 0);
    chk("rst_pulses", {if0.rx_parity_err, if0.rx_frame_err,
                       if0.rx_timeout, if0.rx_overflow}, 0);
    rst = 1'b1;
    tick();

    q0.push_back(8'h1C);
    send0(8'h1C, 1'b0, 1'b1, -1, 1'b1);
    chk("good_valid", if0.rx_valid, 1);
    chk("good_data", if0.rx_data, 8'h1C);
    chk("good_nopulse", {if0.rx_parity_err, if0.rx_frame_err,
                         if0.rx_overflow}, 0);
    tick();
    chk("good_valid_1cyc", if0.rx_valid, 0);

    send0(8'h1C, 1'b1, 1'b1, -1, 1'b1);
    chk("par_err", if0.rx_parity_err, 1);
    chk("par_nopush", if0.rx_valid, 0);
    tick();
    chk("par_err_1cyc", if0.rx_parity_err, 0);

    send0(8'hF0, 1'b1, 1'b0, -1, 1'b1);
    chk("frm_err", if0.rx_frame_err, 1);
    chk("frm_par_ok", if0.rx_parity_err, 0);
    chk("frm_nopush", if0.rx_count, 0);
    tick();
    chk("frm_err_1cyc", if0.rx_frame_err, 0);

    to0 = n_to;
    send_bit(0, 1'b0, GAP);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, GAP);
    n = 0;
    while (!if0.rx_timeout && n < 1000) begin
      tick();
      n++;
    end
    chk("to_latency", n, 200);
    tick();
    chk("to_1cyc", if0.rx_timeout, 0);
    chk("to_once", n_to - to0, 1);
    q0.push_back(8'hF0);
    send0(8'hF0, 1'b1, 1'b1, -1, 1'b1);
    chk("after_to_data", if0.rx_data, 8'hF0);
    chk("after_to_valid", if0.rx_valid, 1);

    to0 = n_to;
    q0.push_back(8'h5A);
    send0(8'h5A, oddp(8'h5A), 1'b1, 4, 1'b1);
    chk("edge_wins_data", if0.rx_data, 8'h5A);
    chk("edge_wins_noto", n_to - to0, 0);
    tick();

    if0.rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(8'h11 * i);
      if (i < 5) q0.push_back(d);
      send0(d, oddp(d), 1'b1, -1, 1'b0);
    end
    chk("ovf_pulse", if0.rx_overflow, 1);
    chk("ovf_count", if0.rx_count, 4);
    tick();
    chk("ovf_1cyc", if0.rx_overflow, 0);
    if0.rx_ready = 1'b1;
    repeat (6) tick();
    chk("ovf_drained", if0.rx_valid, 0);
    chk("ovf_sb_empty", q0.size(), 0);

    if0.rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      q0.push_back(d);
      send0(d, oddp(d), 1'b1, -1, 1'b0);
    end
    q0.push_back(8'h66);
    send0(8'h66, oddp(8'h66), 1'b1, -1, 1'b1);
    if0.rx_ready = 1'b0;
    chk("full_pp_count", if0.rx_count, 4);
    chk("full_pp_noovf", if0.rx_overflow, 0);
    if0.rx_ready = 1'b1;
    repeat (6) tick();
    chk("full_pp_drain", q0.size(), 0);

    to0 = n_to;
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, GAP);
    enable = 1'b0;
    send_bit(0, 1'b0, GAP);
    enable = 1'b1;
    repeat (250) tick();
    chk("ign_count", if0.rx_count, 0);
    chk("ign_noto", n_to - to0, 0);
    chk("ign_noerr", {if0.rx_parity_err, if0.rx_frame_err}, 0);

    if0.rx_ready = 1'b0;
    q0.push_back(8'h33);
    send0(8'h33, oddp(8'h33), 1'b1, -1, 1'b0);
    chk("rst_pre_count", if0.rx_count, 1);
    send_bit(0, 1'b0, GAP);
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1, GAP);
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", if0.rx_valid, 0);
    chk("mid_rst_count", if0.rx_count, 0);
    q0.delete();
    rst = 1'b1;
    if0.rx_ready = 1'b1;
    tick();
    q0.push_back(8'h5A);
    send0(8'h5A, oddp(8'h5A), 1'b1, -1, 1'b1);
    chk("post_rst_valid", if0.rx_valid, 1);
    chk("post_rst_data", if0.rx_data, 8'h5A);

    d = 8'h41;
    q1.push_back(d);
    send_bit(1, 1'b0, GAP);
    for (int i = 0; i < 7; i++) send_bit(1, d[i], GAP);
    send_bit(1, 1'b1, GAP);
    chk("b7_valid", if1.rx_valid, 1);
    chk("b7_data", if1.rx_data, 8'h41);
    chk("b7_noerr", {if1.rx_parity_err, if1.rx_frame_err}, 0);
    send_bit(1, 1'b0, GAP);
    for (int i = 0; i < 7; i++) send_bit(1, d[i], GAP);
    send_bit(1, 1'b0, GAP);
    chk("b7_frm_err", if1.rx_frame_err, 1);
    chk("b7_frm_nopush", if1.rx_valid, 0);

    repeat (5) tick();
    chk("end_sb0", q0.size(), 0);
    chk("end_sb1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
Parametrised PS/2 device-to-host frame receiver, successor to the basic 8-bit byte receiver. It validates the start, parity and stop bits and aborts stalled frames on an inactivity timeout. Good frames are buffered in a small show-ahead FIFO with a valid/ready handshake toward the scancode decoder and Morse encoder. Inputs come from the existing PS/2 synchroniser/edge detector.

Parameters:
DATA_BITS, 8, payload bits per frame, LSB first; legal range 5..9.
PARITY_EN, 1, 1 = frame carries an odd-parity bit that is checked; 0 = no parity bit, so STOP follows DATA.
TIMEOUT_CYCLES, 24000, number of clk cycles without a sampling edge, while mid-frame, before the frame is aborted; must be >= 2.
FIFO_DEPTH, 4, number of entries in the output FIFO; power of 2, >= 2.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous reset, active-low (rst=0 resets on the clk edge).
enable  input  1  permits detection of a new start bit.
ps2_clk_edge  input  1  one-cycle strobe marking the PS/2 data sampling edge.
ps2_data  input  1  synchronised PS/2 data line.
rx_data  output  DATA_BITS  data at the FIFO head.
rx_valid  output  1  FIFO not empty.
rx_ready  input  1  consumer accepts rx_data this cycle.
rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
rx_parity_err  output  1  one-cycle pulse: parity check failed.
rx_frame_err  output  1  one-cycle pulse: stop bit was 0.
rx_timeout  output  1  one-cycle pulse: frame aborted by the timeout.
rx_overflow  output  1  one-cycle pulse: good frame dropped because the FIFO was full.

Behaviour:
- Reset (rst=0): FSM goes to IDLE; bit counter, shift register, timeout counter and FIFO pointers are cleared. All outputs read 0, including rx_data and rx_count. Reset overrides everything, including a frame in progress or a pending push.
- All bit sampling happens only in cycles where ps2_clk_edge=1. ps2_data is ignored in every other cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: an edge with ps2_data=0 and enable=1 moves to DATA. An edge with ps2_data=1, or any edge while enable=0, is ignored and the FSM stays in IDLE.
  - DATA: each edge shifts ps2_data into the MSB and shifts right, so the first data bit ends up in bit 0. The counter counts from 0 to DATA_BITS-1. On the last data edge the counter clears and the FSM moves to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0).
  - PARITY: one edge latches the parity bit, then the FSM moves to STOP.
  - STOP: one edge samples the stop bit, and the FSM always returns to IDLE. The frame is good when stop=1 and, if PARITY_EN=1, XOR(data bits, parity bit)=1.
- Frame outcome on the stop-bit edge cycle N:
  - Parity failed: rx_parity_err=1 in cycle N+1, no push. This takes priority over the frame error.
  - Parity passed but stop=0: rx_frame_err=1 in cycle N+1, no push.
  - Good frame: pushed into the FIFO. rx_valid, rx_count and rx_data reflect it in cycle N+1.
- Deasserting enable mid-frame does not abort the frame; it only blocks the next start bit.
- Timeout:
  - The counter runs only outside IDLE and clears on every ps2_clk_edge.
  - When it reaches TIMEOUT_CYCLES-1 with no edge, the next cycle returns the FSM to IDLE and pulses rx_timeout once.
  - The partial data is discarded and the counter clears.
  - An edge arriving in the same cycle as expiry wins: it is processed normally and no timeout fires.
- FIFO:
  - Show-ahead: rx_data is the head entry, valid whenever rx_valid=1. rx_data is don't-care when the FIFO is empty.
  - A pop occurs when rx_valid=1 and rx_ready=1.
  - A push occurs on a good frame when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Simultaneous push and pop: rx_count is unchanged and order is preserved.
  - Push while full with no pop: the new frame is dropped, rx_overflow pulses, and stored entries are untouched.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - rx_count never exceeds FIFO_DEPTH and never goes below 0; popping while empty has no effect.
- All error and overflow pulses are registered and last exactly one cycle. Only one outcome pulse occurs per frame.

Test Plan:
- Defaults, rx_ready=1: send start 0, data 0x1C LSB-first, parity 0, stop 1 -> rx_valid=1 for one cycle, starting one cycle after the stop edge, with rx_data=0x1C; no error pulses.
- Send 0x1C with parity 1 -> one-cycle rx_parity_err, rx_valid stays 0. Send 0xF0 with parity 1 and stop 0 -> one-cycle rx_frame_err, no push.
- TIMEOUT_CYCLES=200: send start plus 4 data bits, then no edges -> rx_timeout pulses exactly 200 cycles after the last edge and the FSM is back in IDLE. Then send a clean 0xF0 (parity 1) -> rx_data=0xF0.
- rx_ready=0, send 0x11, 0x22, 0x33, 0x44, 0x55 -> rx_count=4 and rx_overflow pulses on the 0x55 frame. Then raise rx_ready -> pops 0x11, 0x22, 0x33, 0x44 in order, then rx_valid=0.
- FIFO full with rx_ready=1 held during the stop-edge cycle of a 5th frame 0x66 -> no overflow and rx_count stays 4. Separately, idle edges with ps2_data=1 and a start bit while enable=0 -> both ignored, nothing received.
- rst=0 asserted after 5 data bits -> next cycle shows rx_valid=0 and rx_count=0. A following clean frame 0x5A is received correctly. Also run a PARITY_EN=0, DATA_BITS=7 instance with 0x41 and a 9-bit frame -> rx_data=0x41.
